// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg -- shared constants, types and helpers for the I2S microphone
// receiver.
//
// Contents:
//   FRAME_SCK   : SCK periods per stereo frame (64).
//   SLOT_SCK    : SCK periods per channel slot (32).
//   OUT_BITS    : width of the emitted audio sample (16).
//   i2s_ch_t    : channel selector, CH_LEFT (WS low) / CH_RIGHT (WS high).
//   sat_round16 : round-half-up of a 16-bit two's-complement field, with
//                 saturation at +full-scale.
// ---------------------------------------------------------------------------
package i2s_pkg;

  localparam int FRAME_SCK = 64;
  localparam int SLOT_SCK  = 32;
  localparam int OUT_BITS  = 16;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_t;

  // Adding the round bit can only overflow at +full-scale; negative values
  // move toward zero (0xFFFF + 1 wraps correctly to 0x0000).
  function automatic logic [OUT_BITS-1:0] sat_round16(
    input logic [OUT_BITS-1:0] top_field,
    input logic                round_bit
  );
    if ((top_field == 16'h7FFF) && round_bit) begin
      return top_field;
    end
    return top_field + {{(OUT_BITS-1){1'b0}}, round_bit};
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// ---------------------------------------------------------------------------
// i2s_sck_gen -- I2S bit clock generator.
//
// Divides clk by 2*CLK_DIV to produce sck. While enable is low the divider,
// sck and the edge strobes are held at zero, so a fresh enable always starts
// with sck low and the first rising edge CLK_DIV cycles later.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   enable   in   run request
//   sck      out  generated bit clock (registered)
//   rise_evt out  one-cycle pulse in the first cycle sck is high
//   fall_evt out  one-cycle pulse in the first cycle sck is low
// ---------------------------------------------------------------------------
module i2s_sck_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic sck,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      sck      <= 1'b0;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end else if (!enable) begin
      div_cnt  <= '0;
      sck      <= 1'b0;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end else begin
      // Strobes are registered alongside sck so they line up with its new level.
      rise_evt <= wrap && !sck;
      fall_evt <= wrap && sck;
      if (wrap) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_mic_receiver.sv
// ---------------------------------------------------------------------------
// i2s_mic_receiver -- I2S master front end for a MEMS microphone.
//
// Generates SCK/WS, captures one channel's SAMPLE_BITS-wide two's-complement
// word MSB-first and emits a 16-bit sample with a one-cycle valid strobe,
// once per 64-SCK frame.
//
// Build option: define MIC_ROUND_EN to round-half-up (with +full-scale
// saturation) instead of truncating the word to 16 bits.
//
// Ports:
//   audio_clk        in   system audio clock
//   rst_in_n         in   asynchronous active-low reset
//   enable_in        in   run request; low holds the interface idle
//   sd_in            in   mic serial data (asynchronous)
//   sck_out          out  I2S bit clock
//   ws_out           out  I2S word select
//   audio_out        out  16-bit signed sample, held between strobes
//   audio_valid_out  out  one-cycle strobe when audio_out updates
// ---------------------------------------------------------------------------
module i2s_mic_receiver
  import i2s_pkg::*;
#(
  parameter int CLK_DIV        = 16,
  parameter int SAMPLE_BITS    = 24,
  parameter int CHANNEL        = 0,
  parameter int STARTUP_FRAMES = 4096
) (
  input  logic                audio_clk,
  input  logic                rst_in_n,
  input  logic                enable_in,
  input  logic                sd_in,
  output logic                sck_out,
  output logic                ws_out,
  output logic [OUT_BITS-1:0] audio_out,
  output logic                audio_valid_out
);

  localparam int BW   = $clog2(FRAME_SCK);
  localparam int KW   = $clog2(SLOT_SCK);
  localparam int SU_W = (STARTUP_FRAMES < 1) ? 1 : $clog2(STARTUP_FRAMES + 1);
  localparam logic [KW-1:0] LAST_K     = KW'(SAMPLE_BITS);
  localparam i2s_ch_t       CAPTURE_CH = (CHANNEL == 0) ? CH_LEFT : CH_RIGHT;

  logic                   rise_evt;
  logic                   fall_evt;
  logic [BW-1:0]          bit_cnt;
  logic [BW-1:0]          bit_cnt_inc;
  logic [KW-1:0]          slot_k;
  logic                   capture_slot;
  logic                   data_bit;
  logic                   sync1;
  logic                   sync2;
  logic                   rise_d1;
  logic                   rise_d2;
  logic [SAMPLE_BITS-1:0] sreg;
  logic                   cap_done;
  logic [SU_W-1:0]        startup_cnt;
  logic [OUT_BITS-1:0]    top_field;
  logic [OUT_BITS-1:0]    conv_val;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (audio_clk),
    .rst_n    (rst_in_n),
    .enable   (enable_in),
    .sck      (sck_out),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  assign bit_cnt_inc  = bit_cnt + 1'b1;
  assign slot_k       = bit_cnt[KW-1:0];
  assign capture_slot = (i2s_ch_t'(bit_cnt[BW-1]) == CAPTURE_CH);
  // k = 0 is the I2S one-bit delay; bits beyond the word are tri-stated.
  assign data_bit     = (slot_k != '0) && (slot_k <= LAST_K);
  assign top_field    = sreg[SAMPLE_BITS-1 -: OUT_BITS];

`ifdef MIC_ROUND_EN
  logic round_bit;
  generate
    if (SAMPLE_BITS > OUT_BITS) begin : g_round_bit
      assign round_bit = sreg[SAMPLE_BITS-OUT_BITS-1];
    end else begin : g_no_round_bit
      assign round_bit = 1'b0;
    end
  endgenerate
  assign conv_val = sat_round16(top_field, round_bit);
`else
  assign conv_val = top_field;
`endif

  // Bits below the output field only matter to the rounding build.
  generate
    if (SAMPLE_BITS > OUT_BITS) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^sreg[SAMPLE_BITS-OUT_BITS-1:0];
    end
  endgenerate

  // Two-flop synchroniser; runs regardless of enable.
  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sd_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      bit_cnt         <= '0;
      ws_out          <= 1'b0;
      rise_d1         <= 1'b0;
      rise_d2         <= 1'b0;
      sreg            <= '0;
      cap_done        <= 1'b0;
      startup_cnt     <= SU_W'(STARTUP_FRAMES);
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
    end else if (!enable_in) begin
      // Idle: partial word discarded, audio_out keeps its last value.
      bit_cnt         <= '0;
      ws_out          <= 1'b0;
      rise_d1         <= 1'b0;
      rise_d2         <= 1'b0;
      sreg            <= '0;
      cap_done        <= 1'b0;
      startup_cnt     <= SU_W'(STARTUP_FRAMES);
      audio_valid_out <= 1'b0;
    end else begin
      // Delay the rise strobe so the sample lines up with the synchronised bit.
      rise_d1 <= rise_evt;
      rise_d2 <= rise_d1;

      if (fall_evt) begin
        bit_cnt <= bit_cnt_inc;
        ws_out  <= bit_cnt_inc[BW-1];
        if ((bit_cnt == '1) && (startup_cnt != '0)) begin
          startup_cnt <= startup_cnt - 1'b1;
        end
      end

      cap_done <= 1'b0;
      if (rise_d2 && capture_slot && data_bit) begin
        sreg     <= {sreg[SAMPLE_BITS-2:0], sync2};
        cap_done <= (slot_k == LAST_K);
      end

      audio_valid_out <= 1'b0;
      if (cap_done && (startup_cnt == '0)) begin
        audio_out       <= conv_val;
        audio_valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_receiver.sv
`timescale 1ns/1ps
// Bench for i2s_mic_receiver: three instances with different configurations
// are driven by a wire-level mic model each, and checked every cycle against
// an arithmetic model of SCK/WS timing and strobe placement.
module tb_i2s_mic_receiver;

  localparam int NI = 3;
  localparam int SB = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          enable;
  logic [NI-1:0] sd = '0;
  logic [NI-1:0] sck;
  logic [NI-1:0] ws;
  logic [NI-1:0] valid;
  logic [15:0]   aud [NI];
  logic [23:0]   word_l;
  logic [23:0]   word_r;

  int tests = 0;
  int fails = 0;

  // Instance 0: CLK_DIV 16, left, no startup. 1: CLK_DIV 4, right, no
  // startup. 2: CLK_DIV 4, left, 2 silent startup frames.
  function automatic int cd_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction
  function automatic int ch_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction
  function automatic int su_of(input int i);
    return (i == 2) ? 2 : 0;
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      i2s_mic_receiver #(
        .CLK_DIV        ((gi == 0) ? 16 : 4),
        .SAMPLE_BITS    (SB),
        .CHANNEL        ((gi == 1) ? 1 : 0),
        .STARTUP_FRAMES ((gi == 2) ? 2 : 0)
      ) u_dut (
        .audio_clk       (clk),
        .rst_in_n        (rst_n),
        .enable_in       (enable),
        .sd_in           (sd[gi]),
        .sck_out         (sck[gi]),
        .ws_out          (ws[gi]),
        .audio_out       (aud[gi]),
        .audio_valid_out (valid[gi])
      );
    end
  endgenerate

  // Expected 16-bit sample from a 24-bit word, computed on signed integers.
  function automatic logic [15:0] conv(input logic [23:0] w);
    int v;
    int r;
    v = {{8{w[23]}}, w};
`ifdef MIC_ROUND_EN
    r = (v + 128) >>> 8;
    if (r > 32767) r = 32767;
`else
    r = v >>> 8;
`endif
    return r[15:0];
  endfunction

  // ---------------- model ----------------
  // run = cycles since enable was first sampled high. SCK half period h;
  // bit b of the stream is sampled on the SCK rise at run (2b+1)h, and the
  // strobe appears LAT cycles later (sync-aligned sample + output register).
  localparam int LAT = 4;
  int          run   [NI];
  logic        exp_v [NI];
  logic [15:0] exp_a [NI];

  function automatic logic fires(input int i, input int r);
    int h;
    int x;
    int per;
    int ofs;
    h   = cd_of(i);
    x   = r - LAT;
    per = 128 * h;
    ofs = (2 * (32 * ch_of(i) + SB) + 1) * h;
    return (x > 0) && ((x % per) == ofs) && ((x / per) >= su_of(i));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        run[i]   <= 0;
        exp_v[i] <= 1'b0;
        exp_a[i] <= 16'h0000;
      end else if (!enable) begin
        run[i]   <= 0;
        exp_v[i] <= 1'b0;
      end else begin
        run[i]   <= run[i] + 1;
        exp_v[i] <= fires(i, run[i] + 1);
        if (fires(i, run[i] + 1)) exp_a[i] <= conv(ch_of(i) == 1 ? word_r : word_l);
      end
    end
  end

  // ---------------- mic model ----------------
  // Latches WS on each SCK rise; a WS change marks the delay bit, and the
  // MSB is driven on the following SCK fall. Unused bit times carry noise.
  logic [NI-1:0] psck = '0;
  logic [NI-1:0] mic_ws = '1;
  int            pos [NI];

  function automatic logic mic_bit(input logic slot, input int p);
    logic [23:0] w;
    w = slot ? word_r : word_l;
    if (p >= 1 && p <= SB) return w[SB-p];
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (run[i] == 0) begin
        mic_ws[i] <= 1'b1;
        pos[i]    <= 0;
        sd[i]     <= 1'b0;
      end else if (sck[i] && !psck[i]) begin
        pos[i]    <= (ws[i] != mic_ws[i]) ? 0 : pos[i] + 1;
        mic_ws[i] <= ws[i];
      end else if (!sck[i] && psck[i]) begin
        sd[i] <= mic_bit(mic_ws[i], pos[i] + 1);
      end
      psck[i] <= sck[i];
    end
  end

  // ---------------- checking ----------------
  int cyc = 0;
  int nstrobe [NI];
  int last_t  [NI];
  int spacing [NI];
  int snap    [NI];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, required %0h", name, idx, cyc, act, req);
    end
  endtask

  task automatic tick(input int n);
    int   h;
    int   r;
    logic e_sck;
    logic e_ws;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        h     = cd_of(i);
        r     = run[i];
        e_sck = (r > 0) && (((r / h) % 2) == 1);
        e_ws  = (r > 0) && ((((r - 1) / (2 * h)) % 64) >= 32);
        check("sck", i, 32'(sck[i]), 32'(e_sck));
        check("ws", i, 32'(ws[i]), 32'(e_ws));
        check("valid", i, 32'(valid[i]), 32'(exp_v[i]));
        check("audio", i, 32'(aud[i]), 32'(exp_a[i]));
        if (valid[i] === 1'b1) begin
          nstrobe[i]++;
          if (last_t[i] >= 0) spacing[i] = cyc - last_t[i];
          last_t[i] = cyc;
          $display("[TB] dut%0d strobe cycle %0d audio_out=%h", i, cyc, aud[i]);
        end
      end
      cyc++;
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < NI; i++) snap[i] = nstrobe[i];
  endtask

  logic [23:0] sign_word [3];
  logic [15:0] sign_exp  [3];
  int          basic_cnt [NI];

  initial begin
    sign_word[0] = 24'h800000;
    sign_word[1] = 24'hFFFF80;
    sign_word[2] = 24'h7FFFFF;
`ifdef MIC_ROUND_EN
    sign_exp[0] = 16'h8000;
    sign_exp[1] = 16'h0000;
    sign_exp[2] = 16'h7FFF;
`else
    sign_exp[0] = 16'h8000;
    sign_exp[1] = 16'hFFFF;
    sign_exp[2] = 16'h7FFF;
`endif
    basic_cnt[0] = 3;
    basic_cnt[1] = 9;
    basic_cnt[2] = 8;
    for (int i = 0; i < NI; i++) begin
      nstrobe[i] = 0;
      last_t[i]  = -1;
      spacing[i] = 0;
    end

    rst_n  = 1'b0;
    enable = 1'b0;
    word_l = 24'h123456;
    word_r = 24'hABCDEF;
    tick(4);
    for (int i = 0; i < NI; i++) begin
      check("reset_audio", i, 32'(aud[i]), 32'h0);
      check("reset_valid", i, 32'(valid[i]), 32'h0);
    end
    rst_n = 1'b1;

    // Idle with enable low.
    take_snap();
    tick(1000);
    for (int i = 0; i < NI; i++) check("idle_strobes", i, nstrobe[i] - snap[i], 0);

    // Basic capture, both channels.
    enable = 1'b1;
    take_snap();
    tick(5000);
    for (int i = 0; i < NI; i++) check("basic_count", i, nstrobe[i] - snap[i], basic_cnt[i]);
    check("basic_value", 0, 32'(aud[0]), 32'h1234);
    check("basic_value", 1, 32'(aud[1]), 32'hABCD);
    check("basic_value", 2, 32'(aud[2]), 32'h1234);
    check("spacing", 0, spacing[0], 2048);
    check("spacing", 1, spacing[1], 512);

    // Sign / rounding / saturation; each run restarts after an enable toggle.
    for (int t = 0; t < 3; t++) begin
      enable = 1'b0;
      tick(4);
      word_l = sign_word[t];
      word_r = sign_word[t];
      enable = 1'b1;
      take_snap();
      if (t == 0) begin
        tick(1220);
        check("startup_silent", 2, nstrobe[2] - snap[2], 0);
        tick(80);
        check("startup_first", 2, nstrobe[2] - snap[2], 1);
      end else begin
        tick(1300);
      end
      for (int i = 0; i < NI; i++) check("sign_value", i, 32'(aud[i]), 32'(sign_exp[t]));
    end

    // Abort at k = 10 of the captured slot (instances 0 and 1).
    enable = 1'b0;
    tick(4);
    word_l = 24'h123456;
    word_r = 24'hABCDEF;
    enable = 1'b1;
    tick(340);
    enable = 1'b0;
    take_snap();
    tick(600);
    for (int i = 0; i < NI; i++) check("abort_strobes", i, nstrobe[i] - snap[i], 0);
    check("abort_hold", 0, 32'(aud[0]), 32'h7FFF);
    check("abort_hold", 1, 32'(aud[1]), 32'h7FFF);
    enable = 1'b1;
    take_snap();
    tick(800);
    check("reenable_count", 0, nstrobe[0] - snap[0], 1);
    check("reenable_value", 0, 32'(aud[0]), 32'h1234);
    check("reenable_value", 1, 32'(aud[1]), 32'hABCD);

    // Asynchronous reset mid-frame.
    tick(300);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("midrst_sck", i, 32'(sck[i]), 32'h0);
      check("midrst_ws", i, 32'(ws[i]), 32'h0);
      check("midrst_audio", i, 32'(aud[i]), 32'h0);
      check("midrst_valid", i, 32'(valid[i]), 32'h0);
    end
    tick(3);
    rst_n = 1'b1;
    tick(900);
    check("post_reset_value", 0, 32'(aud[0]), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
